// File: rtl/cache_ctrl_pkg.sv
// Shared field widths, line geometry and FSM encoding for the cache refill controller.
package cache_ctrl_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 10;
  localparam int TAG_W          = 3;
  localparam int INDEX_W        = 5;
  localparam int OFFSET_W       = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_FILL,
    ST_WRITE
  } state_t;

  // One-hot word enable for a single-word store into a line.
  function automatic logic [WORDS_PER_LINE-1:0] word_mask(input logic [OFFSET_W-1:0] off);
    word_mask      = '0;
    word_mask[off] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_refill_controller_tag_valid_array.sv
// Tag/valid store: combinational read port, single synchronous write port,
// valid bits cleared asynchronously so every line is cold after reset.
module tag_valid_array
  import cache_ctrl_pkg::*;
#(
  parameter int INDEX_SIZE = INDEX_W,
  parameter int TAG_SIZE   = TAG_W
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [INDEX_SIZE-1:0] rd_index,
  output logic [TAG_SIZE-1:0]   rd_tag,
  output logic                  rd_valid,
  input  logic                  we,
  input  logic [INDEX_SIZE-1:0] wr_index,
  input  logic [TAG_SIZE-1:0]   wr_tag
);

  localparam int ENTRIES = 1 << INDEX_SIZE;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_SIZE-1:0] tag_q [ENTRIES];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags carry no reset; they are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/cache_refill_controller.sv
// Direct-mapped cache controller: 4-beat line refill on read miss,
// write-through / no-write-allocate stores, single-cycle line install.
module cache_refill_controller
  import cache_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH           = WORD_W,
  parameter int ADDRESS_WIDTH_CACHE = ADDR_W,
  parameter int TAG_SIZE            = TAG_W,
  parameter int INDEX_SIZE          = INDEX_W,
  parameter int BLOCK_SIZE          = LINE_W
) (
  input  logic                           i_clk,
  input  logic                           i_aresetn,
  input  logic                           i_cpu_rd,
  input  logic                           i_cpu_wr,
  input  logic [ADDRESS_WIDTH_CACHE-1:0] i_cpu_addr,
  input  logic [BUS_WIDTH-1:0]           i_cpu_wdata,
  output logic                           o_cpu_stall,
  output logic                           o_hit,
  output logic                           o_cache_we,
  output logic [INDEX_SIZE-1:0]          o_cache_index,
  output logic [BLOCK_SIZE-1:0]          o_cache_wline,
  output logic [WORDS_PER_LINE-1:0]      o_cache_wmask,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDRESS_WIDTH_CACHE-1:0] o_mem_addr,
  output logic [BUS_WIDTH-1:0]           o_mem_wdata,
  input  logic [BUS_WIDTH-1:0]           i_mem_rdata,
  input  logic                           i_mem_ack
);

  localparam int OFFSET_SIZE = ADDRESS_WIDTH_CACHE - TAG_SIZE - INDEX_SIZE;

  logic [TAG_SIZE-1:0]    addr_tag;
  logic [INDEX_SIZE-1:0]  addr_index;
  logic [OFFSET_SIZE-1:0] addr_offset;

  assign addr_tag    = i_cpu_addr[ADDRESS_WIDTH_CACHE-1 -: TAG_SIZE];
  assign addr_index  = i_cpu_addr[OFFSET_SIZE +: INDEX_SIZE];
  assign addr_offset = i_cpu_addr[OFFSET_SIZE-1:0];

  state_t                                  state_q, state_d;
  logic [OFFSET_SIZE-1:0]                  beat_q;
  logic [WORDS_PER_LINE-1:0][BUS_WIDTH-1:0] line_q;

  logic [TAG_SIZE-1:0] tv_tag;
  logic                tv_valid;
  logic                tv_we;
  logic                stall_c;

  tag_valid_array #(
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE)
  ) u_tag_valid (
    .clk      (i_clk),
    .aresetn  (i_aresetn),
    .rd_index (addr_index),
    .rd_tag   (tv_tag),
    .rd_valid (tv_valid),
    .we       (tv_we),
    .wr_index (addr_index),
    .wr_tag   (addr_tag)
  );

  assign o_hit = tv_valid && (tv_tag == addr_tag);

  // State register plus refill beat counter and line buffer; a reset abandons any beat in flight.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_REFILL && i_mem_ack) begin
        line_q[beat_q] <= i_mem_rdata;
        beat_q         <= beat_q + 1'b1;
      end
    end
  end

  // Next-state and output decode; acks outside REFILL/WRITE fall through unused.
  always_comb begin
    state_d       = state_q;
    stall_c       = 1'b0;
    tv_we         = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_cache_we    = 1'b0;
    o_cache_index = '0;
    o_cache_wline = '0;
    o_cache_wmask = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cpu_wr) begin
          state_d = ST_WRITE;
          stall_c = 1'b1;
        end else if (i_cpu_rd && !o_hit) begin
          state_d = ST_REFILL;
          stall_c = 1'b1;
        end
      end
      ST_REFILL: begin
        stall_c    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_addr = {addr_tag, addr_index, beat_q};
        if (i_mem_ack && (&beat_q)) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        stall_c       = 1'b1;
        tv_we         = 1'b1;
        o_cache_we    = 1'b1;
        o_cache_index = addr_index;
        o_cache_wmask = '1;
        o_cache_wline = line_q;
        state_d       = ST_IDLE;
      end
      ST_WRITE: begin
        stall_c     = !i_mem_ack;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          if (o_hit) begin
            o_cache_we    = 1'b1;
            o_cache_index = addr_index;
            o_cache_wmask = word_mask(addr_offset);
            o_cache_wline = {WORDS_PER_LINE{i_cpu_wdata}};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The IDLE decode would otherwise stall a core that holds a request through reset.
  assign o_cpu_stall = stall_c && i_aresetn;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Bench for cache_refill_controller: directed vector table, delayed-ack and
// mid-refill reset sequences, then randomized accesses against a line-level model.
module tb_cache_refill_controller;

  logic        i_clk = 1'b0;
  logic        i_aresetn;
  logic        i_cpu_rd, i_cpu_wr;
  logic [9:0]  i_cpu_addr;
  logic [31:0] i_cpu_wdata;
  logic        o_cpu_stall, o_hit, o_cache_we;
  logic [4:0]  o_cache_index;
  logic [127:0] o_cache_wline;
  logic [3:0]  o_cache_wmask;
  logic        o_mem_req, o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;

  cache_refill_controller dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn),
    .i_cpu_rd(i_cpu_rd), .i_cpu_wr(i_cpu_wr), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_stall(o_cpu_stall), .o_hit(o_hit),
    .o_cache_we(o_cache_we), .o_cache_index(o_cache_index), .o_cache_wline(o_cache_wline),
    .o_cache_wmask(o_cache_wmask),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_hit;
    int          exp_stall;
  } vec_t;

  typedef struct { logic we; logic [9:0] addr; logic [31:0] wdata; } mreq_t;
  typedef struct { logic [4:0] idx; logic [3:0] mask; logic [127:0] line; } cwr_t;

  int n_vec = 0;
  int n_err = 0;
  int wait_cycles = 0;
  int hold_err = 0;
  int beat_cnt = 0;
  logic [9:0] held_addr;

  logic [31:0] mem_dev [1024];   // the memory device the DUT talks to
  logic [31:0] golden  [1024];   // reference view of memory contents
  logic [31:0] carr    [32][4];  // external cache data array written by the DUT
  logic        valid_m [32];
  logic [2:0]  tag_m   [32];

  mreq_t ack_q[$];
  cwr_t  cw_q[$];

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder with programmable wait states, plus logging of acks and cache writes.
  always @(negedge i_clk) begin
    if (!i_aresetn || !o_mem_req) begin
      i_mem_ack = 1'b0;
      beat_cnt  = 0;
    end else begin
      if (beat_cnt == 0) held_addr = o_mem_addr;
      else if (o_mem_addr != held_addr) hold_err++;
      if (beat_cnt >= wait_cycles) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem_dev[o_mem_addr];
        if (o_mem_we) mem_dev[o_mem_addr] = o_mem_wdata;
        beat_cnt = 0;
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = $urandom;
        beat_cnt++;
      end
    end
    #1;
    if (i_mem_ack && i_aresetn) ack_q.push_back('{o_mem_we, o_mem_addr, o_mem_wdata});
    if (o_cache_we) begin
      cw_q.push_back('{o_cache_index, o_cache_wmask, o_cache_wline});
      for (int w = 0; w < 4; w++)
        if (o_cache_wmask[w]) carr[o_cache_index][w] = o_cache_wline[32*w +: 32];
    end
  end

  // One core access, checked against the model's prediction of hit, stall length,
  // memory traffic and cache-array writes; the model is updated afterwards.
  task automatic do_access(input logic rd, input logic wr, input logic [9:0] a,
                           input logic [31:0] wd, output logic hit0, output int stalls);
    logic [2:0] tg;
    logic [4:0] ix;
    logic [1:0] off;
    logic       p_hit, done, hit_last;
    int         p_stall, exp_n;
    cwr_t       exp_cw;
    tg = a[9:7]; ix = a[6:2]; off = a[1:0];
    p_hit = valid_m[ix] && (tag_m[ix] == tg);
    if (wr)         p_stall = 1 + wait_cycles;
    else if (p_hit) p_stall = 0;
    else            p_stall = 2 + 4 * (wait_cycles + 1);
    ack_q.delete();
    cw_q.delete();
    @(posedge i_clk); #1;
    i_cpu_rd = rd; i_cpu_wr = wr; i_cpu_addr = a; i_cpu_wdata = wd;
    stalls = 0; done = 0; hit0 = 0; hit_last = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge i_clk); #2;
      if (c == 0) hit0 = o_hit;
      if (o_cpu_stall) stalls++;
      else begin done = 1; hit_last = o_hit; end
    end
    @(posedge i_clk); #1;
    i_cpu_rd = 0; i_cpu_wr = 0;
    chk("access_timeout", done, 1'b1);
    chk("hit", hit0, p_hit);
    chk("stall_cycles", stalls, p_stall);
    if (wr) begin
      chk("mem_beats", ack_q.size(), 1);
      if (ack_q.size() == 1) chk("mem_write", {ack_q[0].we, ack_q[0].addr, ack_q[0].wdata}, {1'b1, a, wd});
    end else if (!p_hit) begin
      chk("mem_beats", ack_q.size(), 4);
      if (ack_q.size() == 4)
        for (int k = 0; k < 4; k++) chk("mem_read", {ack_q[k].we, ack_q[k].addr}, {1'b0, a[9:2], k[1:0]});
    end else begin
      chk("mem_beats", ack_q.size(), 0);
    end
    exp_n = 0;
    if (wr && p_hit) begin
      exp_n = 1; exp_cw = '{ix, 4'b0001 << off, {4{wd}}};
    end else if (!wr && !p_hit) begin
      exp_n = 1;
      exp_cw = '{ix, 4'b1111, {golden[{a[9:2], 2'd3}], golden[{a[9:2], 2'd2}],
                              golden[{a[9:2], 2'd1}], golden[{a[9:2], 2'd0}]}};
    end
    chk("cache_writes", cw_q.size(), exp_n);
    if (exp_n == 1 && cw_q.size() == 1)
      chk("cache_wr", {cw_q[0].idx, cw_q[0].mask, cw_q[0].line}, {exp_cw.idx, exp_cw.mask, exp_cw.line});
    if (wr) golden[a] = wd;
    else begin
      chk("rd_hit_final", hit_last, 1'b1);
      chk("rd_data", carr[ix][off], golden[a]);
      valid_m[ix] = 1'b1;
      tag_m[ix]   = tg;
    end
  endtask

  vec_t tbl[7];

  initial begin
    logic h;
    int   s, r, found;
    logic [9:0] ra;

    for (int i = 0; i < 1024; i++) begin
      golden[i]  = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      mem_dev[i] = golden[i];
    end
    for (int i = 0; i < 32; i++) begin
      valid_m[i] = 1'b0; tag_m[i] = '0;
      for (int w = 0; w < 4; w++) carr[i][w] = '0;
    end

    tbl[0] = '{1'b1, 1'b0, 10'h085, 32'h0,         1'b0, 6};
    tbl[1] = '{1'b1, 1'b0, 10'h086, 32'h0,         1'b1, 0};
    tbl[2] = '{1'b0, 1'b1, 10'h085, 32'hDEADBEEF,  1'b1, 1};
    tbl[3] = '{1'b1, 1'b0, 10'h085, 32'h0,         1'b1, 0};
    tbl[4] = '{1'b0, 1'b1, 10'h385, 32'h12345678,  1'b0, 1};
    tbl[5] = '{1'b1, 1'b0, 10'h085, 32'h0,         1'b1, 0};
    tbl[6] = '{1'b1, 1'b1, 10'h086, 32'hCAFEF00D,  1'b1, 1};

    // Reset held with a read pending: every output must stay low.
    i_aresetn = 0; i_cpu_rd = 1; i_cpu_wr = 0; i_cpu_addr = 10'h085; i_cpu_wdata = '0;
    i_mem_ack = 0; i_mem_rdata = '0;
    #12;
    chk("reset_outputs", {o_cpu_stall, o_hit, o_cache_we, o_mem_req, o_mem_we, o_mem_addr, o_cache_wmask},
        '0);
    i_cpu_rd = 0;
    @(negedge i_clk); i_aresetn = 1;

    // Directed table, zero-wait memory.
    wait_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, h, s);
      chk($sformatf("tbl%0d_hit", i), h, tbl[i].exp_hit);
      chk($sformatf("tbl%0d_stall", i), s, tbl[i].exp_stall);
    end
    chk("store_word1_in_array", carr[1][1], 32'hDEADBEEF);

    // Three cycles per beat: 0x385 misses and evicts tag 1, so 0x085 then misses too.
    wait_cycles = 2;
    do_access(1'b1, 1'b0, 10'h385, 32'h0, h, s);
    chk("slow_refill_stall", s, 14);
    do_access(1'b1, 1'b0, 10'h085, 32'h0, h, s);
    chk("evicted_miss", h, 1'b0);
    chk("addr_held_until_ack", hold_err, 0);
    wait_cycles = 0;

    // Reset asserted while beat 2 of a refill is on the bus.
    @(posedge i_clk); #1;
    i_cpu_rd = 1; i_cpu_addr = 10'h0A0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge i_clk); #2;
      if (o_mem_req && o_mem_addr == 10'h0A2) found = 1;
    end
    chk("beat2_reached", found, 1);
    i_aresetn = 0;
    #1;
    chk("midrst_mem_req", o_mem_req, 1'b0);
    chk("midrst_stall", o_cpu_stall, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_aresetn = 1; i_cpu_rd = 0;
    for (int i = 0; i < 32; i++) valid_m[i] = 1'b0;
    do_access(1'b1, 1'b0, 10'h0A0, 32'h0, h, s);
    chk("post_reset_miss", h, 1'b0);

    // Randomized traffic over a few indices so tags collide and lines get evicted.
    for (int n = 0; n < 150; n++) begin
      wait_cycles = $urandom_range(0, 2);
      r  = $urandom_range(0, 9);
      ra = {3'($urandom), 3'b000, 2'($urandom), 2'($urandom)};
      do_access(r >= 9 || r < 6, r >= 6, ra, $urandom, h, s);
    end
    chk("addr_held_final", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_refill_controller.md
CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

Interface
REQ-001 Parameters SHALL be: BUS_WIDTH 32 (word width); ADDRESS_WIDTH_CACHE 10 (word address); TAG_SIZE 3; INDEX_SIZE 5; BLOCK_SIZE 128 (line bits, 4 words).
REQ-002 Ports SHALL be:
- i_clk  in  1  sole clock, rising edge.
- i_aresetn  in  1  reset, asynchronous, active-low.
- i_cpu_rd, i_cpu_wr  in  1 each  core load/store request.
- i_cpu_addr  in  10  word address: tag [9:7], index [6:2], word offset [1:0].
- i_cpu_wdata  in  32  store data.
- o_cpu_stall  out  1  core must hold its request and PC.
- o_hit  out  1  valid and tag match for i_cpu_addr.
- o_cache_we  out  1  cache data array write strobe.
- o_cache_index  out  5  line index for the write.
- o_cache_wline  out  128  line data, word n at bits [32n+31:32n].
- o_cache_wmask  out  4  per-word write enable.
- o_mem_req, o_mem_we  out  1 each  main-memory request / write qualifier.
- o_mem_addr  out  10  main-memory word address.
- o_mem_wdata  out  32  main-memory write data.
- i_mem_rdata  in  32  main-memory read data, valid with ack.
- i_mem_ack  in  1  one-cycle completion of the current beat.

Function
REQ-003 The block SHALL own a 32-entry tag/valid store; o_hit = valid[index] AND tag[index]==addr[9:7], combinational.
REQ-004 FSM states SHALL be IDLE, REFILL, FILL, WRITE.
REQ-005 IDLE: read hit -> stay, stall 0; read miss -> REFILL, stall 1 in that cycle; i_cpu_wr -> WRITE, stall 1; rd and wr both high SHALL be treated as write.
REQ-006 REFILL: o_mem_req=1, o_mem_we=0, o_mem_addr={tag,index,beat}; 2-bit beat counter starts at 0, increments on each ack, wraps 3->0; ack data stored in a 128-bit line buffer at word beat.
REQ-007 The ack for beat 3 SHALL move FSM to FILL; request stays high between beats, address advancing the cycle after each ack.
REQ-008 FILL (exactly 1 cycle): o_cache_we=1, o_cache_wmask=4'b1111, o_cache_wline=line buffer; tag/valid[index] updated; next state IDLE.
REQ-009 WRITE (write-through, no-write-allocate): o_mem_req=1, o_mem_we=1, o_mem_addr=i_cpu_addr, o_mem_wdata=i_cpu_wdata; on ack -> IDLE; if hit, in the ack cycle o_cache_we=1 with one-hot wmask at the word offset and wdata replicated on all four words.
REQ-010 o_cpu_stall SHALL be 1 in REFILL, FILL, in WRITE until the ack cycle (0 in the ack cycle), and per REQ-005 in IDLE.
REQ-011 Zero-wait memory (ack every request cycle): read miss stalls exactly 6 cycles, hit on the 7th; store completes in 2 cycles.
REQ-012 i_mem_ack in IDLE or FILL SHALL be ignored; o_mem_req=0 and o_cache_we=0 outside the states above.
REQ-013 Core SHALL hold address/data stable while stalled; changes mid-miss are not supported.

Reset
REQ-014 Reset SHALL asynchronously force IDLE, beat=0, all valid bits 0, line buffer 0; all outputs 0 while asserted, including mid-REFILL or mid-WRITE (the in-flight beat is abandoned).
REQ-015 After reset release, the first read of any address SHALL miss.

Structure
REQ-016 A shared package cache_ctrl_pkg SHALL hold the state enum, field widths, and words-per-line constant (4).
REQ-017 The tag/valid store SHALL be one sub-module tag_valid_array (async read, sync write, async clear).

Verification
REQ-018 Cold read 0x085, zero-wait memory -> mem addresses 0x084..0x087 in order, stall 6 cycles, FILL at index 1, hit next cycle.
REQ-019 Read 0x086 after REQ-018 -> o_hit=1, stall 0, no memory request.
REQ-020 Store 0x085 data 0xDEADBEEF (hit) -> mem write to 0x085, cache wmask 4'b0010, stall 1 cycle; later read hits returning 0xDEADBEEF from array.
REQ-021 Store 0x385 (miss, tag 7) -> memory write only, o_cache_we stays 0, tag at index 1 unchanged.
REQ-022 Ack delayed 3 cycles per beat -> mem address held until ack, stall 1+4x3+1 cycles; read of 0x385 then evicts tag 1 at index 1.
REQ-023 i_aresetn low during beat 2 of a refill -> o_mem_req 0 immediately, state IDLE, following read of the same address misses again.
